// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
// Owns the register-file write port at the end of the pipeline. Two producers
// share it: the in-order WB stage (GPR, CP0 and mthi/mtlo writes) and the
// long-latency mul/div unit, whose 64-bit {hi,lo} results are buffered in a
// small FIFO and drained one per cycle onto the hi/lo pair write port.
//
// Ordering rule: a WB write to hi or lo is held off (wb_stall) while any
// mul/div result is still queued. Because the FIFO pops every cycle it is
// non-empty, a mthi/mtlo accepted with an empty FIFO can never land in the
// same cycle as a hi/lo pair write, and every older mul/div result has
// already reached the register file by the time the mthi/mtlo does.
module wb_write_arbiter #(
    parameter int DEPTH = 4,    // mul/div result FIFO entries (power of two, >= 2)
    parameter int CNTW  = 3     // occupancy width, log2(DEPTH)+1
) (
    input  logic            clk,
    input  logic            rst,

    // WB stage producer
    input  logic            wb_valid,
    input  logic [6:0]      wb_addr,
    input  logic [31:0]     wb_data,
    output logic            wb_stall,

    // mul/div producer
    input  logic            md_valid,
    input  logic [63:0]     md_hl,
    output logic            md_ready,

    // register-file single write port
    output logic            regwrite,
    output logic [6:0]      write_addr,
    output logic [31:0]     write_data,

    // register-file hi/lo pair write port
    output logic            hl_write_enable_from_wb,
    output logic [63:0]     hl_data,

    // status
    output logic            hl_pending,
    output logic [CNTW-1:0] fifo_count
);

    // Pointer width: the FIFO index, one bit narrower than the occupancy count
    // so that a full FIFO (count == DEPTH) is distinguishable from empty.
    localparam int              PTRW     = CNTW - 1;
    localparam logic [PTRW-1:0] PTR_ONE  = PTRW'(1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [63:0]     r_mem [DEPTH];
    logic [PTRW-1:0] r_wr_ptr;
    logic [PTRW-1:0] r_rd_ptr;
    logic [CNTW-1:0] r_count;

    logic            r_regwrite;
    logic [6:0]      r_write_addr;
    logic [31:0]     r_write_data;
    logic            r_hl_we;
    logic [63:0]     r_hl_data;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic w_fifo_nonempty;
    logic w_fifo_full;
    logic w_push;
    logic w_pop;
    logic w_wb_is_hl;
    logic w_wb_is_gpr0;
    logic w_wb_stall;
    logic w_wb_accept;
    logic w_wb_commit;

    assign w_fifo_nonempty = (r_count != '0);
    assign w_fifo_full     = (r_count == CNT_FULL);

    // A full FIFO refuses a push even when it pops in the same cycle; this
    // keeps md_ready a function of registered state only.
    assign md_ready = ~rst & ~w_fifo_full;
    assign w_push   = md_valid & md_ready;

    // Drain continuously: any queued result goes out on the next edge.
    // There is no bypass, so a fresh push always spends one cycle queued.
    assign w_pop    = w_fifo_nonempty;

    // Bit 6 marks hi/lo (7'h7F hi, 7'h40 lo); only those writes can collide
    // with the hi/lo pair port, so only those wait for the FIFO to drain.
    assign w_wb_is_hl   = wb_addr[6];
    assign w_wb_is_gpr0 = (wb_addr == 7'h00);

    assign w_wb_stall  = ~rst & wb_valid & w_wb_is_hl & w_fifo_nonempty;
    assign w_wb_accept = wb_valid & ~w_wb_stall;

    // A write to GPR 0 is accepted (the WB stage moves on) but discarded.
    assign w_wb_commit = w_wb_accept & ~w_wb_is_gpr0;

    assign wb_stall   = w_wb_stall;
    assign hl_pending = w_fifo_nonempty;
    assign fifo_count = r_count;

    // ------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------

    // Capture a pushed mul/div result at the write pointer.
    // NOTE: the storage array is deliberately not reset; validity is tracked
    // solely by r_count, so clearing the pointers is enough and the array can
    // map onto plain RAM/flops without a reset network.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= md_hl;
        end
    end

    // Advance pointers and occupancy; pointers wrap naturally at DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------

    // Register the popped FIFO head onto the hi/lo pair write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hl_we   <= 1'b0;
            r_hl_data <= '0;
        end else begin
            r_hl_we <= w_pop;
            if (w_pop) begin
                r_hl_data <= r_mem[r_rd_ptr];
            end
        end
    end

    // Register an accepted WB write onto the single write port; address and
    // data hold their last committed values when nothing is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_regwrite   <= 1'b0;
            r_write_addr <= '0;
            r_write_data <= '0;
        end else begin
            r_regwrite <= w_wb_commit;
            if (w_wb_commit) begin
                r_write_addr <= wb_addr;
                r_write_data <= wb_data;
            end
        end
    end

    assign regwrite                = r_regwrite;
    assign write_addr              = r_write_addr;
    assign write_data              = r_write_data;
    assign hl_write_enable_from_wb = r_hl_we;
    assign hl_data                 = r_hl_data;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter
// Drives directed scenarios followed by randomized traffic (including
// mid-run resets) and compares every DUT output against a transaction-level
// model: a queue of pending {hi,lo} results plus the last committed WB write.
module tb_wb_write_arbiter;

    localparam int DEPTH = 4;
    localparam int CNTW  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            wb_valid;
    logic [6:0]      wb_addr;
    logic [31:0]     wb_data;
    logic            wb_stall;
    logic            md_valid;
    logic [63:0]     md_hl;
    logic            md_ready;
    logic            regwrite;
    logic [6:0]      write_addr;
    logic [31:0]     write_data;
    logic            hl_write_enable_from_wb;
    logic [63:0]     hl_data;
    logic            hl_pending;
    logic [CNTW-1:0] fifo_count;

    always #5 clk = ~clk;

    wb_write_arbiter #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .wb_valid                (wb_valid),
        .wb_addr                 (wb_addr),
        .wb_data                 (wb_data),
        .wb_stall                (wb_stall),
        .md_valid                (md_valid),
        .md_hl                   (md_hl),
        .md_ready                (md_ready),
        .regwrite                (regwrite),
        .write_addr              (write_addr),
        .write_data              (write_data),
        .hl_write_enable_from_wb (hl_write_enable_from_wb),
        .hl_data                 (hl_data),
        .hl_pending              (hl_pending),
        .fifo_count              (fifo_count)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model state
    logic [63:0] m_queue [$];
    logic        m_regwrite;
    logic [6:0]  m_waddr;
    logic [31:0] m_wdata;
    logic        m_hl_we;
    logic [63:0] m_hl_data;
    logic        m_last_stall;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: apply inputs, check combinational outputs, advance the
    // model, then check the registered outputs after the edge.
    task automatic cycle(input logic r, input logic wv, input logic [6:0] wa,
                         input logic [31:0] wd, input logic mv, input logic [63:0] mh);
        logic e_stall, e_ready, e_pop, e_push, e_accept;
        logic [63:0] head;
        rst = r; wb_valid = wv; wb_addr = wa; wb_data = wd; md_valid = mv; md_hl = mh;
        #1;
        e_stall = !r && wv && wa[6] && (m_queue.size() != 0);
        e_ready = !r && (m_queue.size() < DEPTH);
        check("wb_stall",   64'(wb_stall),   64'(e_stall));
        check("md_ready",   64'(md_ready),   64'(e_ready));
        check("fifo_count", 64'(fifo_count), 64'(m_queue.size()));
        check("hl_pending", 64'(hl_pending), 64'(m_queue.size() != 0));
        m_last_stall = e_stall;

        if (r) begin
            m_queue.delete();
            m_regwrite = 1'b0; m_waddr = '0; m_wdata = '0;
            m_hl_we = 1'b0; m_hl_data = '0;
        end else begin
            e_pop    = (m_queue.size() != 0);
            e_push   = mv && e_ready;
            e_accept = wv && !e_stall;
            if (e_pop) begin
                head = m_queue.pop_front();
                m_hl_data = head;
            end
            m_hl_we = e_pop;
            if (e_push) m_queue.push_back(mh);
            m_regwrite = e_accept && (wa != 7'h00);
            if (m_regwrite) begin
                m_waddr = wa;
                m_wdata = wd;
            end
        end

        @(posedge clk); #1;
        check("regwrite",   64'(regwrite),   64'(m_regwrite));
        check("write_addr", 64'(write_addr), 64'(m_waddr));
        check("write_data", 64'(write_data), 64'(m_wdata));
        check("hl_we",      64'(hl_write_enable_from_wb), 64'(m_hl_we));
        check("hl_data",    hl_data,         m_hl_data);
        check("hl_exclusive",
              64'(regwrite && write_addr[6] && hl_write_enable_from_wb), 64'(0));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 64'h0);
    endtask

    initial begin
        logic        wv;
        logic [6:0]  wa;
        logic [31:0] wd;
        logic        mv;
        int          rate;

        rst = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        md_valid = 1'b0; md_hl = '0;
        m_regwrite = 1'b0; m_waddr = '0; m_wdata = '0;
        m_hl_we = 1'b0; m_hl_data = '0; m_last_stall = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);

        // Reset state
        cycle(1'b1, 1'b0, 7'h00, 32'h0, 1'b0, 64'h0);

        // GPR write, then GPR 0 write (discarded)
        cycle(1'b0, 1'b1, 7'h05, 32'hDEADBEEF, 1'b0, 64'h0);
        cycle(1'b0, 1'b1, 7'h00, 32'h12345678, 1'b0, 64'h0);
        idle(1);

        // Single mul/div result: queued one cycle, written the next
        cycle(1'b0, 1'b0, 7'h00, 32'h0, 1'b1, 64'h1111_2222_3333_4444);
        idle(2);

        // Back-to-back results drain in order
        for (int k = 0; k < 5; k++)
            cycle(1'b0, 1'b0, 7'h00, 32'h0, 1'b1, {32'hA000_0000 + k, 32'h5000_0000 + k});
        idle(2);

        // mthi behind queued results: held while stalled, written afterwards
        cycle(1'b0, 1'b0, 7'h00, 32'h0, 1'b1, 64'hCAFE_0001_CAFE_0002);
        cycle(1'b0, 1'b1, 7'h7F, 32'hA5A5A5A5, 1'b1, 64'hCAFE_0003_CAFE_0004);
        while (m_last_stall) cycle(1'b0, 1'b1, 7'h7F, 32'hA5A5A5A5, 1'b0, 64'h0);
        idle(2);

        // CP0 write in the same cycle as a pop
        cycle(1'b0, 1'b0, 7'h00, 32'h0, 1'b1, 64'hBEEF_0000_0000_BEEF);
        cycle(1'b0, 1'b1, 7'h2C, 32'h0BAD_F00D, 1'b0, 64'h0);
        idle(1);

        // Reset with results in flight, then no stale writes afterwards
        cycle(1'b0, 1'b0, 7'h00, 32'h0, 1'b1, 64'h0101_0101_0101_0101);
        cycle(1'b1, 1'b1, 7'h03, 32'h3333_3333, 1'b1, 64'h0202_0202_0202_0202);
        idle(3);

        // Randomized traffic with occasional resets and held stalled writes
        wv = 1'b0; wa = '0; wd = '0;
        for (int i = 0; i < 3000; i++) begin
            rate = 25 + 35 * ((i / 500) % 3);
            if (!m_last_stall) begin
                wv = ($urandom_range(0, 99) < 50);
                case ($urandom_range(0, 4))
                    0:       wa = 7'h7F;
                    1:       wa = 7'h40;
                    2:       wa = 7'h20 | 7'($urandom_range(0, 31));
                    3:       wa = 7'h00;
                    default: wa = 7'($urandom_range(0, 31));
                endcase
                wd = $urandom;
            end
            mv = ($urandom_range(0, 99) < rate);
            cycle(($urandom_range(0, 199) == 0), wv, wa, wd, mv, {$urandom, $urandom});
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
